// File: rtl/axi4_lite_arb_pkg.sv
// Shared types and defaults for the AXI4-Lite manager arbiter.
package axi4_lite_arb_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_t;

   typedef enum logic [2:0] {
      IDLE,
      WR_AW_W,
      WR_B,
      RD_AR,
      RD_R,
      DRAIN
   } arb_state_t;

endpackage

// File: rtl/axi4_lite_mgr_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after i_last_grant, wrapping.
module rr_picker #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last_grant,
   output logic [NUM_REQ-1:0] o_grant_c,
   output logic [IDX_W-1:0]   o_idx_c,
   output logic               o_valid_c
);

   logic [31:0] cand;

   always_comb begin
      o_grant_c = '0;
      o_idx_c   = '0;
      o_valid_c = 1'b0;
      cand      = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = (32'(i_last_grant) + i) % NUM_REQ;
         if (!o_valid_c && i_req[IDX_W'(cand)]) begin
            o_valid_c                = 1'b1;
            o_idx_c                  = IDX_W'(cand);
            o_grant_c[IDX_W'(cand)]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi4_lite_mgr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite manager port, one transaction in flight.
// Optional response watchdog with drain: define AXI4_LITE_MGR_ARBITER_TIMEOUT_EN.
module axi4_lite_mgr_arbiter
   import axi4_lite_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned ADDR_BIT_WIDTH = DEF_ADDR_W,
   parameter int unsigned DATA_BIT_WIDTH = DEF_DATA_W,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                                         i_clk,
   input  logic                                         i_sync_rst,
   input  logic [NUM_REQ-1:0]                           i_req_valid,
   output logic [NUM_REQ-1:0]                           o_req_ready,
   input  logic [NUM_REQ-1:0]                           i_req_wr,
   input  logic [NUM_REQ-1:0][ADDR_BIT_WIDTH-1:0]       i_req_addr,
   input  logic [NUM_REQ-1:0][DATA_BIT_WIDTH-1:0]       i_req_wdata,
   input  logic [NUM_REQ-1:0][DATA_BIT_WIDTH/8-1:0]     i_req_wstrb,
   output logic [NUM_REQ-1:0]                           o_rsp_valid,
   output logic [DATA_BIT_WIDTH-1:0]                    o_rsp_rdata,
   output logic [1:0]                                   o_rsp_resp,
   output logic                                         o_awvalid,
   input  logic                                         i_awready,
   output logic [ADDR_BIT_WIDTH-1:0]                    o_awaddr,
   output logic [2:0]                                   o_awprot,
   output logic                                         o_wvalid,
   input  logic                                         i_wready,
   output logic [DATA_BIT_WIDTH-1:0]                    o_wdata,
   output logic [DATA_BIT_WIDTH/8-1:0]                  o_wstrb,
   input  logic                                         i_bvalid,
   output logic                                         o_bready,
   input  logic [1:0]                                   i_bresp,
   output logic                                         o_arvalid,
   input  logic                                         i_arready,
   output logic [ADDR_BIT_WIDTH-1:0]                    o_araddr,
   output logic [2:0]                                   o_arprot,
   input  logic                                         i_rvalid,
   output logic                                         o_rready,
   input  logic [DATA_BIT_WIDTH-1:0]                    i_rdata,
   input  logic [1:0]                                   i_rresp
);

   localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned STRB_W = DATA_BIT_WIDTH / 8;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   arb_state_t                state_q, state_d;
   logic [IDX_W-1:0]          last_grant_q, last_grant_d;   // also the owner of the in-flight transaction
   logic [ADDR_BIT_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_BIT_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]         wstrb_q, wstrb_d;
   logic                      awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic                      arvalid_q, arvalid_d, rready_q, rready_d;
   logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
   logic [DATA_BIT_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   axi_resp_t                 rsp_resp_q, rsp_resp_d;
   logic [NUM_REQ-1:0]        pick_grant;
   logic [IDX_W-1:0]          pick_idx;
   logic                      pick_valid;
   logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs;

   rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
      .i_req        (i_req_valid),
      .i_last_grant (last_grant_q),
      .o_grant_c    (pick_grant),
      .o_idx_c      (pick_idx),
      .o_valid_c    (pick_valid)
   );

   assign aw_hs = awvalid_q && i_awready;
   assign w_hs  = wvalid_q && i_wready;
   assign b_hs  = bready_q && i_bvalid;
   assign ar_hs = arvalid_q && i_arready;
   assign r_hs  = rready_q && i_rvalid;

`ifdef AXI4_LITE_MGR_ARBITER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             drain_done_q, drain_done_d;
`endif

   // Next-state and output computation
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      bready_d     = bready_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      rsp_valid_d  = '0;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_resp_d   = rsp_resp_q;
      o_req_ready  = '0;
`ifdef AXI4_LITE_MGR_ARBITER_TIMEOUT_EN
      tmo_cnt_d    = '0;
      drain_done_d = drain_done_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (pick_valid && !i_sync_rst) begin
               o_req_ready  = pick_grant;
               last_grant_d = pick_idx;
               addr_d       = i_req_addr[pick_idx];
               wdata_d      = i_req_wdata[pick_idx];
               wstrb_d      = i_req_wstrb[pick_idx];
               if (i_req_wr[pick_idx]) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_AW_W;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_AR;
               end
            end
         end
         WR_AW_W: begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WR_B;
            end
         end
         WR_B: begin
            if (b_hs) begin
               bready_d                  = 1'b0;
               rsp_valid_d[last_grant_q] = 1'b1;
               rsp_rdata_d               = '0;
               rsp_resp_d                = axi_resp_t'(i_bresp);
               state_d                   = IDLE;
            end
         end
         RD_AR: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_R;
            end
         end
         RD_R: begin
            if (r_hs) begin
               rready_d                  = 1'b0;
               rsp_valid_d[last_grant_q] = 1'b1;
               rsp_rdata_d               = i_rdata;
               rsp_resp_d                = axi_resp_t'(i_rresp);
               state_d                   = IDLE;
            end
         end
`ifdef AXI4_LITE_MGR_ARBITER_TIMEOUT_EN
         DRAIN: begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            if (ar_hs) arvalid_d = 1'b0;
            drain_done_d = drain_done_q || b_hs || r_hs;
            if (!awvalid_d && !wvalid_d && !arvalid_d && drain_done_d) begin
               bready_d = 1'b0;
               rready_d = 1'b0;
               state_d  = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
`ifdef AXI4_LITE_MGR_ARBITER_TIMEOUT_EN
      // Watchdog: abandon the stalled stage with SLVERR, then drain the late handshakes
      if (state_q inside {WR_AW_W, WR_B, RD_AR, RD_R}) begin
         if (aw_hs || w_hs || b_hs || ar_hs || r_hs) begin
            tmo_cnt_d = '0;
         end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid_d[last_grant_q] = 1'b1;
            rsp_rdata_d               = '0;
            rsp_resp_d                = SLVERR;
            bready_d                  = state_q inside {WR_AW_W, WR_B};
            rready_d                  = state_q inside {RD_AR, RD_R};
            drain_done_d              = 1'b0;
            state_d                   = DRAIN;
         end else begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
         end
      end
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_sync_rst) begin
         state_q      <= IDLE;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         rsp_valid_q  <= '0;
         rsp_rdata_q  <= '0;
         rsp_resp_q   <= OKAY;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         bready_q     <= bready_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_resp_q   <= rsp_resp_d;
      end
   end

`ifdef AXI4_LITE_MGR_ARBITER_TIMEOUT_EN
   always_ff @(posedge i_clk) begin
      if (i_sync_rst) begin
         tmo_cnt_q    <= '0;
         drain_done_q <= 1'b0;
      end else begin
         tmo_cnt_q    <= tmo_cnt_d;
         drain_done_q <= drain_done_d;
      end
   end
`endif

   // Responses outside their acceptance window are ignored but flagged
   always_ff @(posedge i_clk) begin
      if (!i_sync_rst) begin
         assert (!(i_bvalid && !bready_q)) else $error("bvalid seen outside B phase");
         assert (!(i_rvalid && !rready_q)) else $error("rvalid seen outside R phase");
      end
   end

   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_resp  = rsp_resp_q;
   assign o_awvalid   = awvalid_q;
   assign o_awaddr    = addr_q;
   assign o_awprot    = 3'b000;
   assign o_wvalid    = wvalid_q;
   assign o_wdata     = wdata_q;
   assign o_wstrb     = wstrb_q;
   assign o_bready    = bready_q;
   assign o_arvalid   = arvalid_q;
   assign o_araddr    = addr_q;
   assign o_arprot    = 3'b000;
   assign o_rready    = rready_q;

endmodule

// File: tb/tb_axi4_lite_mgr_arbiter.sv
// Directed self-checking bench for axi4_lite_mgr_arbiter (2 requesters, 32-bit bus).
module tb_axi4_lite_mgr_arbiter;

   logic             clk;
   logic             rst;
   logic [1:0]       req_valid, req_ready, req_wr, rsp_valid;
   logic [1:0][31:0] req_addr, req_wdata;
   logic [1:0][3:0]  req_wstrb;
   logic [31:0]      rsp_rdata;
   logic [1:0]       rsp_resp;
   logic             awvalid, awready, wvalid, wready, bvalid, bready;
   logic             arvalid, arready, rvalid, rready;
   logic [31:0]      awaddr, araddr, wdata, rdata;
   logic [3:0]       wstrb;
   logic [2:0]       awprot, arprot;
   logic [1:0]       bresp, rresp;

   int checks = 0;
   int errors = 0;

   axi4_lite_mgr_arbiter #(
      .NUM_REQ(2), .ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32), .TIMEOUT_CYCLES(16)
   ) dut (
      .i_clk(clk), .i_sync_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wr(req_wr),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp),
      .o_awvalid(awvalid), .i_awready(awready), .o_awaddr(awaddr), .o_awprot(awprot),
      .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata), .o_wstrb(wstrb),
      .i_bvalid(bvalid), .o_bready(bready), .i_bresp(bresp),
      .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr), .o_arprot(arprot),
      .i_rvalid(rvalid), .o_rready(rready), .i_rdata(rdata), .i_rresp(rresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1;
      req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;

      // Reset state
      tick(); tick();
      #1;
      check("rst_awvalid", 64'(awvalid), 64'h0);
      check("rst_wvalid", 64'(wvalid), 64'h0);
      check("rst_arvalid", 64'(arvalid), 64'h0);
      check("rst_bready", 64'(bready), 64'h0);
      check("rst_rready", 64'(rready), 64'h0);
      check("rst_req_ready", 64'(req_ready), 64'h0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      check("rst_awaddr", 64'(awaddr), 64'h0);
      check("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
      rst = 1'b0;

      // Req0 zero-wait write
      tick();
      req_valid = 2'b01; req_wr = 2'b01;
      req_addr[0] = 32'h0000_0010; req_wdata[0] = 32'hDEAD_BEEF; req_wstrb[0] = 4'hF;
      awready = 1'b1; wready = 1'b1;
      #1 check("wr_grant", 64'(req_ready), 64'h1);
      tick();
      req_valid = 2'b00;
      #1;
      check("wr_awvalid", 64'(awvalid), 64'h1);
      check("wr_wvalid", 64'(wvalid), 64'h1);
      check("wr_awaddr", 64'(awaddr), 64'h10);
      check("wr_wdata", 64'(wdata), 64'hDEAD_BEEF);
      check("wr_wstrb", 64'(wstrb), 64'hF);
      check("wr_awprot", 64'(awprot), 64'h0);
      check("wr_ready_pulse", 64'(req_ready), 64'h0);
      tick();
      bvalid = 1'b1; bresp = 2'b00;
      #1;
      check("wr_bready", 64'(bready), 64'h1);
      check("wr_aw_dropped", 64'(awvalid), 64'h0);
      check("wr_no_early_rsp", 64'(rsp_valid), 64'h0);
      tick();
      bvalid = 1'b0;
      #1;
      check("wr_rsp_valid", 64'(rsp_valid), 64'h1);
      check("wr_rsp_resp", 64'(rsp_resp), 64'h0);
      check("wr_rsp_rdata", 64'(rsp_rdata), 64'h0);

      // Req1 read with three-cycle arready stall
      tick();
      awready = 1'b0; wready = 1'b0;
      req_valid = 2'b10; req_wr = 2'b00; req_addr[1] = 32'h0000_0004;
      #1 check("rd_grant", 64'(req_ready), 64'h2);
      tick();
      req_valid = 2'b00;
      #1;
      check("rd_arvalid_s1", 64'(arvalid), 64'h1);
      check("rd_araddr", 64'(araddr), 64'h4);
      tick();
      #1 check("rd_arvalid_s2", 64'(arvalid), 64'h1);
      tick();
      #1 check("rd_arvalid_s3", 64'(arvalid), 64'h1);
      tick();
      arready = 1'b1;
      #1;
      check("rd_arvalid_hs", 64'(arvalid), 64'h1);
      check("rd_araddr_stable", 64'(araddr), 64'h4);
      tick();
      arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
      #1;
      check("rd_rready", 64'(rready), 64'h1);
      check("rd_ar_dropped", 64'(arvalid), 64'h0);
      tick();
      rvalid = 1'b0;
      #1;
      check("rd_rsp_valid", 64'(rsp_valid), 64'h2);
      check("rd_rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
      check("rd_rsp_resp", 64'(rsp_resp), 64'h0);

      // Both requesters continuously valid: alternating grants, back-to-back
      tick();
      req_valid = 2'b11; req_wr = 2'b00;
      req_addr[0] = 32'h0000_0100; req_addr[1] = 32'h0000_0104;
      arready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         logic [1:0]  exp_oh;
         logic [31:0] exp_addr;
         exp_oh   = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_addr = (k % 2 == 0) ? 32'h100 : 32'h104;
         #1 check("rr_grant", 64'(req_ready), 64'(exp_oh));
         tick();
         #1;
         check("rr_arvalid", 64'(arvalid), 64'h1);
         check("rr_araddr", 64'(araddr), 64'(exp_addr));
         check("rr_no_aw", 64'(awvalid), 64'h0);
         check("rr_no_grant_busy", 64'(req_ready), 64'h0);
         tick();
         rvalid = 1'b1; rdata = 32'(k);
         #1;
         check("rr_rready", 64'(rready), 64'h1);
         check("rr_ar_idle", 64'(arvalid), 64'h0);
         tick();
         rvalid = 1'b0;
         if (k == 5) req_valid = 2'b00;
         #1;
         check("rr_rsp_valid", 64'(rsp_valid), 64'(exp_oh));
         check("rr_rsp_rdata", 64'(rsp_rdata), 64'(k));
      end
      arready = 1'b0;

      // wready lags awready by two cycles
      tick();
      req_valid = 2'b01; req_wr = 2'b01;
      req_addr[0] = 32'h0000_0020; req_wdata[0] = 32'hA5A5_0001; req_wstrb[0] = 4'h3;
      awready = 1'b1; wready = 1'b0;
      #1 check("wl_grant", 64'(req_ready), 64'h1);
      tick();
      req_valid = 2'b00;
      #1;
      check("wl_awvalid", 64'(awvalid), 64'h1);
      check("wl_wvalid", 64'(wvalid), 64'h1);
      tick();
      #1;
      check("wl_aw_dropped", 64'(awvalid), 64'h0);
      check("wl_w_held1", 64'(wvalid), 64'h1);
      check("wl_no_bready", 64'(bready), 64'h0);
      tick();
      wready = 1'b1;
      #1;
      check("wl_w_held2", 64'(wvalid), 64'h1);
      check("wl_wstrb", 64'(wstrb), 64'h3);
      tick();
      wready = 1'b0; awready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
      #1;
      check("wl_w_dropped", 64'(wvalid), 64'h0);
      check("wl_bready", 64'(bready), 64'h1);
      tick();
      bvalid = 1'b0;
      #1 check("wl_rsp_valid", 64'(rsp_valid), 64'h1);
      tick();
      #1;
      check("wl_single_rsp", 64'(rsp_valid), 64'h0);
      check("wl_bready_low", 64'(bready), 64'h0);

      // Reset while waiting for B
      tick();
      req_valid = 2'b01; req_wr = 2'b01; awready = 1'b1; wready = 1'b1;
      #1 check("rs_grant", 64'(req_ready), 64'h1);
      tick();
      req_valid = 2'b00;
      #1 check("rs_awvalid", 64'(awvalid), 64'h1);
      tick();
      #1 check("rs_in_wr_b", 64'(bready), 64'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_valid = 2'b11; req_wr = 2'b00; awready = 1'b0; wready = 1'b0; arready = 1'b1;
      #1;
      check("rs_awvalid_low", 64'(awvalid), 64'h0);
      check("rs_wvalid_low", 64'(wvalid), 64'h0);
      check("rs_bready_low", 64'(bready), 64'h0);
      check("rs_no_rsp", 64'(rsp_valid), 64'h0);
      check("rs_grant_req0", 64'(req_ready), 64'h1);
      tick();
      req_valid = 2'b00;
      #1;
      check("rs_no_rsp_late", 64'(rsp_valid), 64'h0);
      check("rs_arvalid", 64'(arvalid), 64'h1);
      check("rs_araddr", 64'(araddr), 64'h20);
      tick();
      arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_CAFE;
      #1 check("rs_rready", 64'(rready), 64'h1);
      tick();
      rvalid = 1'b0;
      #1;
      check("rs_rsp_valid", 64'(rsp_valid), 64'h1);
      check("rs_rsp_rdata", 64'(rsp_rdata), 64'hCAFE);

`ifdef AXI4_LITE_MGR_ARBITER_TIMEOUT_EN
      // B never arrives in time: SLVERR after 16 cycles in WR_B, late B drained silently
      tick();
      req_valid = 2'b10; req_wr = 2'b10; req_addr[1] = 32'h0000_0030;
      awready = 1'b1; wready = 1'b1;
      #1 check("to_grant", 64'(req_ready), 64'h2);
      tick();
      req_valid = 2'b00;
      tick();
      awready = 1'b0; wready = 1'b0;
      #1 check("to_in_wr_b", 64'(bready), 64'h1);
      for (int i = 1; i < 16; i++) begin
         tick();
         #1 check("to_wait_no_rsp", 64'(rsp_valid), 64'h0);
      end
      tick();
      #1;
      check("to_rsp_valid", 64'(rsp_valid), 64'h2);
      check("to_rsp_resp", 64'(rsp_resp), 64'h2);
      check("to_rsp_rdata", 64'(rsp_rdata), 64'h0);
      for (int i = 0; i < 23; i++) begin
         tick();
         #1;
         check("to_drain_bready", 64'(bready), 64'h1);
         check("to_drain_no_rsp", 64'(rsp_valid), 64'h0);
      end
      tick();
      bvalid = 1'b1; bresp = 2'b00;
      #1 check("to_late_b_ready", 64'(bready), 64'h1);
      tick();
      bvalid = 1'b0;
      req_valid = 2'b01; req_wr = 2'b00;
      #1;
      check("to_late_b_silent", 64'(rsp_valid), 64'h0);
      check("to_bready_low", 64'(bready), 64'h0);
      check("to_idle_grant", 64'(req_ready), 64'h1);
      tick();
      req_valid = 2'b00;
`endif

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
